// File: rtl/voice_tone_scheduler.sv
// Shares one note-to-divider lookup among NUM_VOICES voices by round-robin scanning
// and runs a square-wave divider per voice. Optional VOICE_MIX_EN adds registered mix_level.
module voice_tone_scheduler #(
  parameter int NUM_VOICES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [NUM_VOICES*7-1:0]               voice_note,
  output logic [6:0]                            lookup_note,
  input  logic [19:0]                           lookup_max,
  output logic [$clog2(NUM_VOICES)-1:0]         scan_idx,
  output logic [NUM_VOICES-1:0]                 voice_wave,
  output logic [NUM_VOICES-1:0]                 voice_active
`ifdef VOICE_MIX_EN
  ,
  output logic [$clog2(NUM_VOICES+1)-1:0]       mix_level
`endif
);

  localparam int IW = $clog2(NUM_VOICES);

  logic [IW-1:0]           scan_idx_q, scan_idx_d;
  logic [19:0]             max_q  [NUM_VOICES];
  logic [19:0]             max_d  [NUM_VOICES];
  logic [19:0]             cnt_q  [NUM_VOICES];
  logic [19:0]             cnt_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   wave_q, wave_d;
  logic [NUM_VOICES-1:0]   wr_sel;
  logic [NUM_VOICES-1:0]   max_chg;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    scan_idx_d = scan_idx_q;
    if (en) begin
      scan_idx_d = (scan_idx_q == IW'(NUM_VOICES - 1)) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // The shared table sees the note of the voice under refresh.
  always_comb begin
    lookup_note = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (scan_idx_q == IW'(i)) lookup_note = voice_note[7*i +: 7];
    end
  end

  always_comb begin
    wr_sel  = '0;
    max_chg = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      wr_sel[i]  = (scan_idx_q == IW'(i));
      max_chg[i] = wr_sel[i] && (lookup_max != max_q[i]);
    end
  end

  // NOTE: combinational next-state uses blocking '=' so later statements see
  // earlier results; the flops below use non-blocking '<=' so all registers
  // update together at the edge.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      max_d[i]  = max_q[i];
      cnt_d[i]  = cnt_q[i];
      wave_d[i] = wave_q[i];
      if (en) begin
        if (wr_sel[i]) max_d[i] = lookup_max;
        // Priority: silent voice, then retune restart, then half-period wrap.
        if (max_q[i] == 20'd0) begin
          cnt_d[i]  = '0;
          wave_d[i] = 1'b0;
        end else if (max_chg[i]) begin
          cnt_d[i] = '0;
          if (lookup_max == 20'd0) wave_d[i] = 1'b0;
        end else if (cnt_q[i] >= max_q[i] - 20'd1) begin
          cnt_d[i]  = '0;
          wave_d[i] = ~wave_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

  // NOTE: the max/cnt arrays are reset explicitly because voice_active and the
  // wave outputs are decoded straight from them and must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx_q <= '0;
      wave_q     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        max_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      scan_idx_q <= scan_idx_d;
      wave_q     <= wave_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        max_q[i] <= max_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    voice_active = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_active[i] = (max_q[i] != 20'd0);
    end
  end

  assign scan_idx   = scan_idx_q;
  assign voice_wave = wave_q;

`ifdef VOICE_MIX_EN
  localparam int MW = $clog2(NUM_VOICES + 1);

  logic [MW-1:0] mix_q, mix_d, wave_pop;

  // Popcount of the next-state waves so the level lines up with voice_wave.
  always_comb begin
    wave_pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      wave_pop = wave_pop + MW'(wave_d[i]);
    end
    mix_d = en ? wave_pop : mix_q;
  end

  always_ff @(posedge clk) begin
    if (rst) mix_q <= '0;
    else     mix_q <= mix_d;
  end

  assign mix_level = mix_q;
`endif

endmodule

// File: tb/tb_voice_tone_scheduler.sv
// Self-checking bench for voice_tone_scheduler: directed scenarios plus random
// notes/enable/reset against a closed-form tone model (toggle count = elapsed/max).
module tb_voice_tone_scheduler;

  localparam int NV = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [NV*7-1:0] voice_note;
  logic [6:0]      lookup_note;
  logic [19:0]     lookup_max;
  logic [1:0]      scan_idx;
  logic [NV-1:0]   voice_wave;
  logic [NV-1:0]   voice_active;
`ifdef VOICE_MIX_EN
  logic [2:0]      mix_level;
`endif

  logic [6:0] notes [NV];

  int n_cmp = 0;
  int n_err = 0;

  // Model: enabled-edge count since reset, and per voice the latched max, the
  // edge at which its counter last restarted and the wave level at that restart.
  int n;
  int m_max   [NV];
  int m_start [NV];
  bit m_sw    [NV];

  logic [1:0]    exp_idx;
  logic [6:0]    exp_note;
  logic [NV-1:0] exp_wave;
  logic [NV-1:0] exp_active;
  int            exp_mix;

  voice_tone_scheduler #(.NUM_VOICES(NV)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .voice_note   (voice_note),
    .lookup_note  (lookup_note),
    .lookup_max   (lookup_max),
    .scan_idx     (scan_idx),
    .voice_wave   (voice_wave),
    .voice_active (voice_active)
`ifdef VOICE_MIX_EN
    ,
    .mix_level    (mix_level)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NV; i++) voice_note[7*i +: 7] = notes[i];
  end

  function automatic logic [19:0] tbl(input logic [6:0] note);
    case (note)
      7'h00:   return 20'h00000;
      7'h7f:   return 20'h001a6;
      7'h7e:   return 20'h001bf;
      default: return 20'(1 + int'(note) % 9);
    endcase
  endfunction

  assign lookup_max = tbl(lookup_note);

  function automatic bit model_wave(input int i, input int nn);
    if (m_max[i] == 0) return 1'b0;
    return m_sw[i] ^ bit'(((nn - m_start[i]) / m_max[i]) % 2);
  endfunction

  function automatic string got_s();
    return $sformatf("idx=%0d note=%h wave=%b act=%b", scan_idx, lookup_note, voice_wave, voice_active);
  endfunction

  function automatic string want_s();
    return $sformatf("idx=%0d note=%h wave=%b act=%b", exp_idx, exp_note, exp_wave, exp_active);
  endfunction

  // Advance one clock from a negedge; the model consumes the same pre-edge inputs.
  task automatic tick(input logic e, input logic r);
    int idx;
    int nm;
    en  = e;
    rst = r;
    if (r) begin
      n = 0;
      for (int i = 0; i < NV; i++) begin
        m_max[i] = 0; m_start[i] = 0; m_sw[i] = 1'b0;
      end
    end else if (e) begin
      idx = n % NV;
      nm  = int'(tbl(notes[idx]));
      if (nm != m_max[idx]) begin
        m_sw[idx]    = (nm == 0) ? 1'b0 : model_wave(idx, n);
        m_start[idx] = n + 1;
        m_max[idx]   = nm;
      end
      n++;
    end
    @(posedge clk);
    #1;
    exp_idx  = 2'(n % NV);
    exp_note = notes[n % NV];
    for (int i = 0; i < NV; i++) begin
      exp_wave[i]   = model_wave(i, n);
      exp_active[i] = (m_max[i] != 0);
    end
    exp_mix = $countones(exp_wave);
    @(negedge clk);
  endtask

  // Latching edge number for voice v given the current model edge count.
  function automatic int next_latch(input int v);
    int le;
    le = n + 1;
    while ((le - 1) % NV != v) le++;
    return le;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < NV; i++) notes[i] = 7'h7f;
    for (int k = 0; k < 2; k++) begin
      tick(1'(k == 0), 1'b1);
      n_cmp++;
      if ({scan_idx, lookup_note, voice_wave, voice_active} !== {2'd0, 7'h7f, 4'b0000, 4'b0000}) begin
        n_err++;
        $display("FAIL reset(en=%0d) got %s want idx=0 note=7f wave=0000 act=0000", k == 0, got_s());
      end
`ifdef VOICE_MIX_EN
      n_cmp++;
      if (mix_level !== 3'd0) begin
        n_err++;
        $display("FAIL reset_mix got %0d want 0", mix_level);
      end
`endif
    end
  endtask

  task automatic test_full_tone();
    int first_rise [NV];
    int first_fall [NV];
    for (int i = 0; i < NV; i++) begin first_rise[i] = -1; first_fall[i] = -1; end
    for (int k = 0; k < 900; k++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if ({scan_idx, lookup_note, voice_wave, voice_active} !== {exp_idx, exp_note, exp_wave, exp_active}) begin
        n_err++;
        $display("FAIL full_tone n=%0d got %s want %s", n, got_s(), want_s());
      end
`ifdef VOICE_MIX_EN
      n_cmp++;
      if (mix_level !== 3'(exp_mix)) begin
        n_err++;
        $display("FAIL full_tone_mix n=%0d got %0d want %0d", n, mix_level, exp_mix);
      end
`endif
      if (k == 3) begin
        n_cmp++;
        if (voice_active !== 4'b1111) begin
          n_err++;
          $display("FAIL all_latched got act=%b want 1111", voice_active);
        end
      end
      for (int i = 0; i < NV; i++) begin
        if (voice_wave[i] === 1'b1 && first_rise[i] < 0) first_rise[i] = n;
        if (voice_wave[i] === 1'b0 && first_rise[i] >= 0 && first_fall[i] < 0) first_fall[i] = n;
      end
    end
    for (int i = 0; i < NV; i++) begin
      n_cmp++;
      if (first_rise[i] != 423 + i || first_fall[i] != 845 + i) begin
        n_err++;
        $display("FAIL tone_timing v%0d got rise=%0d fall=%0d want rise=%0d fall=%0d",
                 i, first_rise[i], first_fall[i], 423 + i, 845 + i);
      end
    end
  endtask

  task automatic test_note_change();
    int le;
    int te;
    int seen;
    logic prev;
    notes[2] = 7'h7e;
    le   = next_latch(2);
    te   = le + 447;
    seen = -1;
    prev = voice_wave[2];
    for (int k = 0; k < 600 && n < te + 5; k++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if ({scan_idx, lookup_note, voice_wave, voice_active} !== {exp_idx, exp_note, exp_wave, exp_active}) begin
        n_err++;
        $display("FAIL note_change n=%0d got %s want %s", n, got_s(), want_s());
      end
      if (n >= le && voice_wave[2] !== prev && seen < 0) seen = n;
      prev = voice_wave[2];
    end
    n_cmp++;
    if (seen != te) begin
      n_err++;
      $display("FAIL retune_toggle got edge %0d want edge %0d", seen, te);
    end
  endtask

  task automatic test_silence();
    int le;
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if ({scan_idx, lookup_note, voice_wave, voice_active} !== {exp_idx, exp_note, exp_wave, exp_active}) begin
        n_err++;
        $display("FAIL silence_wait n=%0d got %s want %s", n, got_s(), want_s());
      end
      hit = (voice_wave[1] === 1'b1);
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL silence_wait_timeout got wave1=%b want 1", voice_wave[1]);
    end
    notes[1] = 7'h00;
    le = next_latch(1);
    while (n < le) tick(1'b1, 1'b0);
    n_cmp++;
    if ({voice_wave[1], voice_active[1]} !== 2'b00) begin
      n_err++;
      $display("FAIL silence_latch got wave1=%b act1=%b want 0 0", voice_wave[1], voice_active[1]);
    end
    for (int k = 0; k < 300; k++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if ({scan_idx, lookup_note, voice_wave, voice_active} !== {exp_idx, exp_note, exp_wave, exp_active}
          || voice_wave[1] !== 1'b0) begin
        n_err++;
        $display("FAIL silence_hold n=%0d got %s want %s", n, got_s(), want_s());
      end
    end
    notes[1] = 7'h7f;
  endtask

  task automatic test_en_hold();
    logic [16:0] saved;
    saved = {scan_idx, lookup_note, voice_wave, voice_active};
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, 1'b0);
      n_cmp++;
      if ({scan_idx, lookup_note, voice_wave, voice_active} !== saved) begin
        n_err++;
        $display("FAIL en_hold k=%0d got %s want frozen %h", k, got_s(), saved);
      end
    end
    for (int k = 0; k < 500; k++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if ({scan_idx, lookup_note, voice_wave, voice_active} !== {exp_idx, exp_note, exp_wave, exp_active}) begin
        n_err++;
        $display("FAIL en_resume n=%0d got %s want %s", n, got_s(), want_s());
      end
    end
  endtask

  task automatic test_mid_reset();
    int rise0;
    rise0 = -1;
    tick(1'b1, 1'b1);
    n_cmp++;
    if ({scan_idx, voice_wave, voice_active} !== {2'd0, 4'b0000, 4'b0000}) begin
      n_err++;
      $display("FAIL mid_reset got %s want idx=0 wave=0000 act=0000", got_s());
    end
    for (int k = 0; k < 430; k++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if ({scan_idx, lookup_note, voice_wave, voice_active} !== {exp_idx, exp_note, exp_wave, exp_active}) begin
        n_err++;
        $display("FAIL post_reset n=%0d got %s want %s", n, got_s(), want_s());
      end
      if (voice_wave[0] === 1'b1 && rise0 < 0) rise0 = n;
    end
    n_cmp++;
    if (rise0 != 423) begin
      n_err++;
      $display("FAIL post_reset_toggle got edge %0d want 423", rise0);
    end
  endtask

  function automatic logic [6:0] rand_note();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 3)  return 7'h00;
    if (r == 3) return 7'h7f;
    return 7'($urandom_range(1, 7'h7d));
  endfunction

  task automatic test_random();
    for (int i = 0; i < NV; i++) notes[i] = rand_note();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) notes[$urandom_range(0, NV - 1)] = rand_note();
      tick(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 299) == 0));
      n_cmp++;
      if ({scan_idx, lookup_note, voice_wave, voice_active} !== {exp_idx, exp_note, exp_wave, exp_active}) begin
        n_err++;
        $display("FAIL random n=%0d got %s want %s", n, got_s(), want_s());
      end
`ifdef VOICE_MIX_EN
      n_cmp++;
      if (mix_level !== 3'(exp_mix)) begin
        n_err++;
        $display("FAIL random_mix n=%0d got %0d want %0d", n, mix_level, exp_mix);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < NV; i++) notes[i] = 7'h00;
    test_reset();
    test_full_tone();
    test_note_change();
    test_silence();
    test_en_hold();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/voice_tone_scheduler.md
# voice_tone_scheduler

Polyphonic tone controller that shares one combinational note-to-divider lookup (`note_div_table`) among `NUM_VOICES` voices. It scans voices round-robin, presents each voice's note to the table and latches the returned 20-bit half-period into a per-voice register. It also runs one divider counter per voice to produce square waves. It sits between the note/keyboard front end and the audio output/mixer stage.

## Interface
Parameters:
- `NUM_VOICES`, default 4, number of voices; must be ≥2.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: when high, scanning and counting advance; when low, all state holds.
- `voice_note` input `NUM_VOICES*7`: voice i's note is bits [7i+6:7i]. Note 0 means silent.
- `lookup_note` output 7: note driven to the shared `note_div_table`. Combinational: `voice_note` slice selected by `scan_idx`.
- `lookup_max` input 20: `max` returned by the table. The block treats it as combinational in the same cycle.
- `scan_idx` output `$clog2(NUM_VOICES)`: voice currently being refreshed.
- `voice_wave` output `NUM_VOICES`: per-voice square wave.
- `voice_active` output `NUM_VOICES`: bit i high when voice i's latched max is non-zero.
- `mix_level` output `$clog2(NUM_VOICES+1)`: count of `voice_wave` bits that are high. Present only with `VOICE_MIX_EN`.

## Operation
- Scanner:
  - `scan_idx` increments on each `en` cycle and wraps from `NUM_VOICES-1` to 0.
  - At each `en` edge, `max_reg[scan_idx] <= lookup_max`.
- Change detect:
  - If the value being written differs from the current `max_reg[scan_idx]`, that voice's counter is cleared to 0 on the same edge and no toggle occurs that cycle.
  - A write with the same value has no side effect.
- Per-voice counter (20 bits), evaluated on each `en` edge and checked in this order:
  1. `max_reg == 0`: `cnt <= 0`, `wave <= 0`.
  2. A changing write to this voice this edge: `cnt <= 0`, wave unchanged. If the new max is 0, `wave <= 0` instead.
  3. `cnt >= max_reg - 1`: `cnt <= 0`, wave toggles.
  4. Otherwise: `cnt <= cnt + 1`.
- Resulting period:
  - Half-period is exactly `max_reg` enabled cycles.
  - Full period is `2*max_reg` enabled cycles.
- `voice_active[i] = (max_reg[i] != 0)`, taken combinationally from the register.

## Timing
- Reset values: `scan_idx` = 0, all `max_reg` = 0, all `cnt` = 0, `voice_wave` = 0, `voice_active` = 0, `mix_level` = 0.
- `lookup_note` after reset reflects voice 0's note.
- Note-change latency: a new note on voice i is latched within at most `NUM_VOICES` enabled cycles. The first toggle of the new tone comes `max` enabled cycles after the latching edge.
- `en` low: no state changes. `scan_idx` and `lookup_note` remain stable.
- Reset asserted mid-operation: all state returns to reset values at the next edge, regardless of `en`.
- Boundary cases:
  - Wrap of `scan_idx` is seamless, with no idle cycle.
  - Notes changing on several voices simultaneously are serviced in scan order.

## Configuration
- `VOICE_MIX_EN`:
  - Defined: `mix_level` port exists, registered, updated every `en` edge from the next-state `voice_wave`. `mix_level` = popcount of the next-state `voice_wave`, visible in the same cycle as the waves. Reset value 0.
  - Undefined: port and logic are absent; behaviour of all other outputs is identical.

## Test plan
- Reset with all notes = 0x7f, `en` = 1: after 4 cycles all `max_reg` = 0x001a6. `voice_wave[i]` toggles every 422 enabled cycles, with phase offset equal to i cycles.
- Voice 2 note 0x7f → 0x7e mid-tone: `max_reg[2]` becomes 0x001bf on voice 2's scan edge and `cnt[2]` clears. The next toggle comes 447 cycles later; other voices are undisturbed.
- Voice 1 note 0x7f → 0x00 while `wave[1]` = 1: on voice 1's scan edge `wave[1]` drops to 0 and `voice_active[1]` drops to 0. Voice 1 then stays silent.
- `en` held low for 100 cycles mid-tone: `scan_idx`, counters and waves are frozen. After release, the toggle arrives exactly the remaining count later.
- `rst` pulsed for 1 cycle mid-tone: all outputs are 0 the following cycle. Tones resume after the rescan, with the first toggle 422 cycles after each voice's latching edge.
- With `VOICE_MIX_EN`, all four voices on note 0x7f and in phase from reset (same note, so only scan offset matters): `mix_level` steps 0→1→2→3→4 on consecutive cycles at first toggle.
